// File: rtl/accum_alu_pkg.sv
// Shared opcode and mode definitions for the accumulator ALU.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package accum_alu_pkg;

  typedef enum logic [3:0] {
    OP_LOOKUP = 4'b0000,
    OP_LOADR  = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_MOVE   = 4'b0100,
    OP_LOADM  = 4'b0101,
    OP_STORE  = 4'b0110,
    OP_SHL    = 4'b0111,
    OP_SHR    = 4'b1000,
    OP_AND    = 4'b1001,
    OP_XOR    = 4'b1010,
    OP_EQ     = 4'b1011,
    OP_LT     = 4'b1100,
    OP_GT     = 4'b1101,
    OP_RSVD   = 4'b1110,
    OP_BZ     = 4'b1111
  } alu_op_t;

  // Mode selects the instruction class; only OP_BZ looks at it.
  localparam logic MODE_ALU = 1'b0;
  localparam logic MODE_BR  = 1'b1;

endpackage

// File: rtl/accum_alu_if.sv
// Operand/result bundle between the datapath driver and the ALU.
// Latency: none (wires only).
// Backpressure: none; the ALU accepts a new operation every cycle.
interface accum_alu_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] R0;
  logic [WIDTH-1:0] Input;
  logic             Mode;
  logic [3:0]       OP;
  logic [WIDTH-1:0] Out;
  logic             Zero;
  logic             C_out;

  modport master (
    output R0, Input, Mode, OP,
    input  Out, Zero, C_out
  );

  modport slave (
    input  R0, Input, Mode, OP,
    output Out, Zero, C_out
  );

endinterface

// File: rtl/accum_alu_carry_flag.sv
// Carry/borrow status register updated by ADD and SUB.
// Latency: one clock edge from operands to flag.
// Backpressure: none; every other opcode simply holds the flag.
module accum_alu_carry_flag
  import accum_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] in_b,
  output logic             c_out
);

  logic [WIDTH:0] sum_ext;
  logic           borrow;

  assign sum_ext = {1'b0, r0} + {1'b0, in_b};
  assign borrow  = (r0 < in_b);

  // Reset wins; ADD captures the carry-out, SUB the borrow, anything else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_out <= 1'b0;
    end else begin
      case (op)
        OP_ADD:  c_out <= sum_ext[WIDTH];
        OP_SUB:  c_out <= borrow;
        default: c_out <= c_out;
      endcase
    end
  end

endmodule

// File: rtl/accum_alu.sv
// 8-bit accumulator ALU: combinational result/zero plus registered carry flag.
// Latency: Out/Zero zero-cycle combinational; C_out updates on the next CLK edge.
// Backpressure: none; a new operation may be presented every cycle.
module accum_alu
  import accum_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  accum_alu_if.slave  bus
);

  alu_op_t          op;
  logic [WIDTH-1:0] out_c;

  assign op = alu_op_t'(bus.OP);

  // Result mux: one arm per opcode; reserved and unknown codes yield zero.
  always_comb begin
    out_c = '0;
    case (op)
      OP_LOOKUP,
      OP_LOADR,
      OP_LOADM,
      OP_STORE: out_c = bus.Input;
      OP_ADD:   out_c = bus.R0 + bus.Input;
      OP_SUB:   out_c = bus.R0 - bus.Input;
      OP_MOVE:  out_c = bus.R0;
      OP_SHL:   out_c = {bus.Input[WIDTH-2:0], 1'b0};
      OP_SHR:   out_c = {1'b0, bus.Input[WIDTH-1:1]};
      OP_AND:   out_c = bus.R0 & bus.Input;
      OP_XOR:   out_c = bus.R0 ^ bus.Input;
      OP_EQ:    out_c = {{(WIDTH-1){1'b0}}, (bus.R0 == bus.Input)};
      OP_LT:    out_c = {{(WIDTH-1){1'b0}}, (bus.R0 <  bus.Input)};
      OP_GT:    out_c = {{(WIDTH-1){1'b0}}, (bus.R0 >  bus.Input)};
      OP_BZ: begin
        // Branch target is only forwarded in branch mode with a zero accumulator.
        if ((bus.Mode == MODE_BR) && (bus.R0 == '0)) begin
          out_c = bus.Input;
        end
      end
      default:  out_c = '0;
    endcase
  end

  assign bus.Out  = out_c;
  assign bus.Zero = (out_c == '0);

  accum_alu_carry_flag #(
    .WIDTH (WIDTH)
  ) u_carry_flag (
    .clk   (CLK),
    .rst   (Reset),
    .op    (op),
    .r0    (bus.R0),
    .in_b  (bus.Input),
    .c_out (bus.C_out)
  );

endmodule

// File: tb/tb_accum_alu.sv
// Scoreboard bench for accum_alu: directed plan followed by random operations.
// Latency: checks Out/Zero in the issue cycle and C_out as left by the prior edge.
// Backpressure: none; the monitor drains one expected entry per cycle.
module tb_accum_alu;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       zero;
    logic       cout;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  int   model_carry;

  accum_alu_if #(.WIDTH(8)) bus ();

  accum_alu #(.WIDTH(8)) dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain unsigned integer arithmetic.
  function automatic int ref_out(int op, int mode, int a, int b);
    case (op)
      0, 1, 5, 6: return b;
      2:  return (a + b) % 256;
      3:  return (a - b + 256) % 256;
      4:  return a;
      7:  return (b * 2) % 256;
      8:  return b / 2;
      9:  return a & b;
      10: return a ^ b;
      11: return (a == b) ? 1 : 0;
      12: return (a < b) ? 1 : 0;
      13: return (a > b) ? 1 : 0;
      15: return (mode == 1 && a == 0) ? b : 0;
      default: return 0;
    endcase
  endfunction

  // Present one operation after the edge and queue what the monitor must see.
  task automatic apply(input string name, input int rst, input int op,
                       input int mode, input int a, input int b);
    exp_t e;
    int   r;
    @(posedge clk);
    #1;
    reset      = rst[0];
    bus.OP     = op[3:0];
    bus.Mode   = mode[0];
    bus.R0     = a[7:0];
    bus.Input  = b[7:0];
    r          = ref_out(op, mode, a, b);
    e.name     = name;
    e.out      = r[7:0];
    e.zero     = (r == 0);
    e.cout     = model_carry[0];
    exp_q.push_back(e);
    if (rst != 0)     model_carry = 0;
    else if (op == 2) model_carry = (a + b > 255) ? 1 : 0;
    else if (op == 3) model_carry = (a < b) ? 1 : 0;
  endtask

  // Monitor: pop and compare whenever an issued operation is on the bus.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.Out !== e.out) begin
        errors++;
        $display("FAIL %s out: got %02h need %02h", e.name, bus.Out, e.out);
      end
      checks++;
      if (bus.Zero !== e.zero) begin
        errors++;
        $display("FAIL %s zero: got %b need %b", e.name, bus.Zero, e.zero);
      end
      checks++;
      if (bus.C_out !== e.cout) begin
        errors++;
        $display("FAIL %s c_out: got %b need %b", e.name, bus.C_out, e.cout);
      end
    end
  end

  initial begin
    int op, mode, a, b, rst, waited;
    checks      = 0;
    errors      = 0;
    model_carry = 0;
    reset       = 1'b1;
    bus.OP      = 4'd0;
    bus.Mode    = 1'b0;
    bus.R0      = 8'd0;
    bus.Input   = 8'd0;
    repeat (2) @(posedge clk);

    // Data moves
    apply("reset_state", 0, 0, 0, 1, 10);
    apply("loadr",  0, 1, 0, 1, 10);
    apply("loadm",  0, 5, 0, 1, 10);
    apply("store",  0, 6, 0, 1, 10);
    apply("move",   0, 4, 0, 1, 2);
    // Arithmetic and flag
    apply("rst_pulse", 1, 9, 0, 0, 0);
    apply("add_1_1",   0, 2, 0, 1, 1);
    apply("add_80_80", 0, 2, 0, 8'h80, 8'h80);
    apply("sub_2_1",   0, 3, 0, 2, 1);
    apply("sub_0_1",   0, 3, 0, 0, 1);
    apply("and_hold",  0, 9, 0, 5, 3);
    apply("add_ff_01", 0, 2, 0, 8'hFF, 1);
    // Shifts and logic
    apply("shl_01", 0, 7, 0, 0, 1);
    apply("shl_80", 0, 7, 0, 0, 8'h80);
    apply("shr_02", 0, 8, 0, 0, 2);
    apply("shr_01", 0, 8, 0, 0, 1);
    apply("and_5_3", 0, 9, 0, 5, 3);
    apply("xor_5_3", 0, 10, 0, 5, 3);
    // Compares
    apply("eq_3_3", 0, 11, 0, 3, 3);
    apply("eq_1_3", 0, 11, 0, 1, 3);
    apply("lt_1_3", 0, 12, 0, 1, 3);
    apply("lt_3_3", 0, 12, 0, 3, 3);
    apply("gt_3_1", 0, 13, 0, 3, 1);
    apply("gt_3_3", 0, 13, 0, 3, 3);
    // Branch and reserved
    apply("bz_taken",   0, 15, 1, 0, 8'hFF);
    apply("bz_nz",      0, 15, 1, 1, 8'hFF);
    apply("bz_mode0",   0, 15, 0, 0, 8'hFF);
    apply("rsvd",       0, 14, 1, 5, 7);
    // Reset mid-stream with carry set
    apply("set_carry",  0, 3, 0, 0, 1);
    apply("hold_carry", 0, 9, 0, 8'hF0, 8'h0F);
    apply("rst_add",    1, 2, 0, 8'hFF, 1);
    apply("after_rst",  0, 9, 0, 8'hFF, 1);

    // Random operations with boundary-biased operands
    for (int i = 0; i < 300; i++) begin
      op   = int'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 1));
      a    = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 255 : 0)
                                         : int'($urandom_range(0, 255));
      b    = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 128 : 1)
                                         : int'($urandom_range(0, 255));
      rst  = ($urandom_range(0, 15) == 0) ? 1 : 0;
      apply("random", rst, op, mode, a, b);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
